vga_sincronismo: RTL

//   VGA 640x480@60 timing generator. Upstream of every VGA_* ship/grid renderer.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_divisor_pixel.sv | 30 +++
 rtl/vga_sincronismo.sv | 78 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, their derived limits, and a small range helper.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int CLK_DIV  = 2;
    localparam bit SYNC_POL = 1'b0;

    localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_INI = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_FIM = H_SYNC_INI + H_SYNC - 1;
    localparam int V_SYNC_INI = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_FIM = V_SYNC_INI + V_SYNC - 1;

    // Inclusive range test on 10-bit counts.
    function automatic logic em_faixa(input logic [9:0] valor,
                                      input logic [9:0] ini,
                                      input logic [9:0] fim);
        return (valor >= ini) && (valor <= fim);
    endfunction

endpackage

// File: rtl/vga_divisor_pixel.sv
// Pixel-rate enable: one registered pulse every CLK_DIV system clocks.
// With CLK_DIV=1 the pulse is high on every clock after reset release.
module vga_divisor_pixel #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLK_DIV-1; the enable is registered on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pixel_en <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt      <= '0;
            pixel_en <= 1'b1;
        end else begin
            cnt      <= cnt + CW'(1);
            pixel_en <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_sincronismo.sv
// VGA timing generator: H/V counters, sync and active-area decode, frame-start pulse.
// Sync/active flags are decoded from the next-state counts so they line up with linha/coluna.
module vga_sincronismo #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK,
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter bit SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixelEn,
    output logic [9:0] coluna,
    output logic [9:0] linha,
    output logic       areaAtiva,
    output logic       hsync,
    output logic       vsync,
    output logic       inicioQuadro
);

    localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] H_INI = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_FIM = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_INI = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_FIM = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [9:0] coluna_prox;
    logic [9:0] linha_prox;

    vga_divisor_pixel #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixel_en (pixelEn)
    );

    // Next position: column wraps at end of line, line advances only on that wrap.
    always_comb begin
        coluna_prox = coluna + 10'd1;
        linha_prox  = linha;
        if (coluna == H_MAX) begin
            coluna_prox = '0;
            linha_prox  = (linha == V_MAX) ? '0 : linha + 10'd1;
        end
    end

    // Output registers advance on pixelEn and hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coluna       <= H_MAX;
            linha        <= V_MAX;
            areaAtiva    <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            inicioQuadro <= 1'b0;
        end else begin
            inicioQuadro <= 1'b0;
            if (pixelEn) begin
                coluna       <= coluna_prox;
                linha        <= linha_prox;
                areaAtiva    <= (coluna_prox < H_ACT) && (linha_prox < V_ACT);
                hsync        <= vga_pkg::em_faixa(coluna_prox, H_INI, H_FIM) ? SYNC_POL : ~SYNC_POL;
                vsync        <= vga_pkg::em_faixa(linha_prox, V_INI, V_FIM) ? SYNC_POL : ~SYNC_POL;
                inicioQuadro <= (coluna_prox == '0) && (linha_prox == '0);
            end
        end
    end

endmodule
